// File: rtl/ccip_mmio_responder.sv
// AFU-side CCI-P MMIO target: DFH/AFU_ID header, scratch CSRs, and a
// pending-read FIFO that lets completions wait out c2_stall without loss.
module ccip_mmio_responder #(
    parameter logic [63:0] DFH_VALUE   = 64'h1000_0000_0000_1000,
    parameter logic [63:0] AFU_ID_L    = 64'h0,
    parameter logic [63:0] AFU_ID_H    = 64'h0,
    parameter int          NUM_SCRATCH = 4,
    parameter int          FIFO_DEPTH  = 8
) (
    input  logic                     pClk,
    input  logic                     pck_cp2af_softReset_n,
    input  logic                     c0_mmioRdValid,
    input  logic                     c0_mmioWrValid,
    input  logic [15:0]              c0_mmio_address,
    input  logic [1:0]               c0_mmio_length,
    input  logic [8:0]               c0_mmio_tid,
    input  logic [63:0]              c0_data,
    input  logic                     c2_stall,
    output logic                     c2_mmioRdValid,
    output logic [8:0]               c2_tid,
    output logic [63:0]              c2_data,
    output logic [64*NUM_SCRATCH-1:0] scratch_o,
    output logic                     err_o
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [NUM_SCRATCH-1:0][63:0] r_scratch;
    logic [8:0]                   r_fifo_tid  [FIFO_DEPTH];
    logic [63:0]                  r_fifo_data [FIFO_DEPTH];
    logic [AW:0]                  r_wptr, r_rptr;
    logic                         r_err;

    logic [14:0] w_idx;
    logic [63:0] w_reg;
    logic [31:0] w_half;
    logic [63:0] w_rd_data;
    logic        w_len_ok, w_8b, w_misal;
    logic        w_rd_req, w_wr_req;
    logic        w_empty, w_full, w_pop, w_push, w_err_set;

    // 8-byte register index: address is in dwords, two per register
    assign w_idx    = c0_mmio_address[15:1];
    assign w_len_ok = (c0_mmio_length < 2'd2);
    assign w_8b     = (c0_mmio_length == 2'd1);
    assign w_misal  = w_8b & c0_mmio_address[0];

    always_comb begin
        w_reg = 64'h0;
        case (w_idx)
            15'd0:   w_reg = DFH_VALUE;
            15'd1:   w_reg = AFU_ID_L;
            15'd2:   w_reg = AFU_ID_H;
            default: begin
                for (int i = 0; i < NUM_SCRATCH; i++)
                    if (w_idx == 15'(4 + i)) w_reg = r_scratch[i];
            end
        endcase
    end

    assign w_half    = c0_mmio_address[0] ? w_reg[63:32] : w_reg[31:0];
    assign w_rd_data = w_8b ? (w_misal ? 64'h0 : w_reg) : {w_half, w_half};

    assign w_rd_req = c0_mmioRdValid & w_len_ok;
    assign w_wr_req = c0_mmioWrValid & w_len_ok & ~w_misal;

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_pop   = ~w_empty & ~c2_stall;
    // a pop in the same cycle frees a slot, so a full FIFO can still accept
    assign w_push  = w_rd_req & (~w_full | w_pop);

    assign w_err_set = ((c0_mmioRdValid | c0_mmioWrValid) & ~w_len_ok)
                     | ((c0_mmioRdValid | c0_mmioWrValid) & w_len_ok & w_misal)
                     | (c0_mmioRdValid & c0_mmioWrValid)
                     | (w_rd_req & w_full & ~w_pop);

    always_ff @(posedge pClk) begin
        if (w_push) begin
            r_fifo_tid[r_wptr[AW-1:0]]  <= c0_mmio_tid;
            r_fifo_data[r_wptr[AW-1:0]] <= w_rd_data;
        end
    end

    always_ff @(posedge pClk or negedge pck_cp2af_softReset_n) begin
        if (!pck_cp2af_softReset_n) begin
            r_scratch      <= '0;
            r_wptr         <= '0;
            r_rptr         <= '0;
            r_err          <= 1'b0;
            c2_mmioRdValid <= 1'b0;
            c2_tid         <= '0;
            c2_data        <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            c2_mmioRdValid <= w_pop;
            if (w_pop) begin
                r_rptr  <= r_rptr + 1'b1;
                c2_tid  <= r_fifo_tid[r_rptr[AW-1:0]];
                c2_data <= r_fifo_data[r_rptr[AW-1:0]];
            end
            if (w_err_set) r_err <= 1'b1;
            for (int i = 0; i < NUM_SCRATCH; i++) begin
                if (w_wr_req && w_idx == 15'(4 + i)) begin
                    if (w_8b)                    r_scratch[i]        <= c0_data;
                    else if (c0_mmio_address[0]) r_scratch[i][63:32] <= c0_data[31:0];
                    else                         r_scratch[i][31:0]  <= c0_data[31:0];
                end
            end
        end
    end

    assign scratch_o = r_scratch;
    assign err_o     = r_err;
endmodule

// File: tb/tb_ccip_mmio_responder.sv
// Randomized and directed bench for ccip_mmio_responder against a
// byte-address / queue based reference model.
module tb_ccip_mmio_responder;
    localparam logic [63:0] DFH  = 64'h1000_0000_0000_1000;
    localparam logic [63:0] IDL  = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] IDH  = 64'hFEDC_BA98_7654_3210;
    localparam int          NS   = 4;
    localparam int          DEP  = 8;

    logic        pClk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rd = 0, wr = 0, stall = 0;
    logic [15:0] addr = 0;
    logic [1:0]  len = 0;
    logic [8:0]  tid = 0;
    logic [63:0] wdata = 0;
    logic        c2_vld;
    logic [8:0]  c2_tid;
    logic [63:0] c2_data;
    logic [64*NS-1:0] scratch;
    logic        err;

    ccip_mmio_responder #(.DFH_VALUE(DFH), .AFU_ID_L(IDL), .AFU_ID_H(IDH),
                          .NUM_SCRATCH(NS), .FIFO_DEPTH(DEP)) dut (
        .pClk(pClk), .pck_cp2af_softReset_n(rst_n),
        .c0_mmioRdValid(rd), .c0_mmioWrValid(wr), .c0_mmio_address(addr),
        .c0_mmio_length(len), .c0_mmio_tid(tid), .c0_data(wdata),
        .c2_stall(stall), .c2_mmioRdValid(c2_vld), .c2_tid(c2_tid),
        .c2_data(c2_data), .scratch_o(scratch), .err_o(err));

    always #5 pClk = ~pClk;

    typedef struct { logic [8:0] tid; logic [63:0] data; } cpl_t;
    cpl_t        q[$];
    logic [63:0] m_scr [NS];
    logic        m_vld, m_err;
    logic [8:0]  m_tid;
    logic [63:0] m_data;
    int          n_chk = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] reg_at(int b);
        if (b == 0)  return DFH;
        if (b == 8)  return IDL;
        if (b == 16) return IDH;
        if (b >= 32 && b < 32 + 8*NS) return m_scr[(b-32)/8];
        return 64'h0;
    endfunction

    function automatic logic [63:0] model_rd(int b, int l);
        logic [63:0] r;
        logic [31:0] h;
        if (l == 1) return (b % 8 != 0) ? 64'h0 : reg_at(b);
        r = reg_at(b - (b % 8));
        h = (b % 8 == 4) ? r[63:32] : r[31:0];
        return {h, h};
    endfunction

    task automatic model_wr(int b, int l, logic [63:0] d);
        int base, k;
        base = b - (b % 8);
        if (base < 32 || base >= 32 + 8*NS) return;
        k = (base - 32) / 8;
        if (l == 1) begin
            if (b % 8 == 0) m_scr[k] = d;
        end else if (b % 8 == 4) m_scr[k][63:32] = d[31:0];
        else                     m_scr[k][31:0]  = d[31:0];
    endtask

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < NS; i++) m_scr[i] = 64'h0;
        m_vld = 0; m_err = 0; m_tid = 0; m_data = 0;
    endtask

    task automatic check_all(input string pfx);
        chk({pfx, "_vld"}, 64'(c2_vld), 64'(m_vld));
        chk({pfx, "_tid"}, 64'(c2_tid), 64'(m_tid));
        chk({pfx, "_data"}, c2_data, m_data);
        chk({pfx, "_err"}, 64'(err), 64'(m_err));
        for (int i = 0; i < NS; i++)
            chk($sformatf("%s_scr%0d", pfx, i), scratch[64*i +: 64], m_scr[i]);
    endtask

    // one clock: model the edge from the inputs currently driven, then compare
    task automatic step(input string pfx);
        int   b;
        cpl_t c;
        @(posedge pClk);
        b = int'(addr) * 4;
        if (q.size() > 0 && !stall) begin
            c = q.pop_front(); m_vld = 1; m_tid = c.tid; m_data = c.data;
        end else m_vld = 0;
        if ((rd || wr) && len > 1) m_err = 1;
        if ((rd || wr) && len == 1 && (b % 8 != 0)) m_err = 1;
        if (rd && wr) m_err = 1;
        if (rd && len < 2) begin
            c.tid = tid; c.data = model_rd(b, int'(len));
            if (q.size() < DEP) q.push_back(c);
            else m_err = 1;
        end
        if (wr && len < 2) model_wr(b, int'(len), wdata);
        #1;
        check_all(pfx);
    endtask

    task automatic drive(input logic r, input logic w, input logic [15:0] a,
                         input logic [1:0] l, input logic [8:0] t,
                         input logic [63:0] d, input logic s);
        rd = r; wr = w; addr = a; len = l; tid = t; wdata = d; stall = s;
    endtask

    task automatic idle(input logic s);
        drive(0, 0, 16'h0, 2'd0, 9'h0, 64'h0, s);
    endtask

    task automatic do_reset();
        #1;
        rst_n = 0;
        #2;
        model_reset();
        chk("rst_vld", 64'(c2_vld), 64'h0);
        chk("rst_tid", 64'(c2_tid), 64'h0);
        chk("rst_data", c2_data, 64'h0);
        chk("rst_err", 64'(err), 64'h0);
        for (int i = 0; i < NS; i++) chk($sformatf("rst_scr%0d", i), scratch[64*i +: 64], 64'h0);
        @(posedge pClk);
        #1;
        rst_n = 1;
    endtask

    initial begin
        model_reset();
        idle(0);
        @(posedge pClk);
        do_reset();

        // basic DFH read and its 2-cycle latency
        drive(1, 0, 16'h0000, 2'd1, 9'h05, 64'h0, 0); step("t1a");
        idle(0); step("t1b");
        chk("t1_vld", 64'(c2_vld), 64'h1);
        chk("t1_tid", 64'(c2_tid), 64'h05);
        chk("t1_data", c2_data, DFH);
        idle(0); step("t1c");
        chk("t1_one_cycle", 64'(c2_vld), 64'h0);

        // scratch0 write then upper-half 4 B read
        drive(0, 1, 16'h0008, 2'd1, 9'h0, 64'hDEAD_BEEF_0123_4567, 0); step("t2a");
        chk("t2_scr0", scratch[63:0], 64'hDEAD_BEEF_0123_4567);
        drive(1, 0, 16'h0009, 2'd0, 9'h1FF, 64'h0, 0); step("t2b");
        idle(0); step("t2c");
        chk("t2_tid", 64'(c2_tid), 64'h1FF);
        chk("t2_data", c2_data, 64'hDEADBEEF_DEADBEEF);

        // stalled burst keeps order and pre-write data
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, 16'h0008, 2'd1, 9'(i), 64'h0, 1); step("t3r");
        end
        drive(0, 1, 16'h0008, 2'd1, 9'h0, 64'h0, 1); step("t3w");
        for (int i = 0; i < 10; i++) begin
            idle(0); step("t3d");
            if (i < 8) begin
                chk("t3_vld", 64'(c2_vld), 64'h1);
                chk("t3_tid", 64'(c2_tid), 64'(i));
                chk("t3_data", c2_data, 64'hDEAD_BEEF_0123_4567);
            end
        end
        chk("t3_err", 64'(err), 64'h0);

        // overflow drops tid 8
        for (int i = 0; i < 9; i++) begin
            drive(1, 0, 16'h0008, 2'd1, 9'(i), 64'h0, 1); step("t4r");
        end
        chk("t4_err", 64'(err), 64'h1);
        for (int i = 0; i < 12; i++) begin
            idle(0); step("t4d");
            if (c2_vld) chk("t4_no_tid8", 64'(c2_tid == 9'd8), 64'h0);
        end
        chk("t4_err_sticky", 64'(err), 64'h1);

        // read-only AFU_ID_L and misaligned 8 B read
        do_reset();
        drive(0, 1, 16'h0002, 2'd1, 9'h0, 64'h1111_2222_3333_4444, 0); step("t5w");
        drive(1, 0, 16'h0002, 2'd1, 9'h21, 64'h0, 0); step("t5r");
        idle(0); step("t5i");
        chk("t5_idl", c2_data, IDL);
        chk("t5_err0", 64'(err), 64'h0);
        drive(1, 0, 16'h0003, 2'd1, 9'h22, 64'h0, 0); step("t5m");
        idle(0); step("t5n");
        chk("t5_mis_data", c2_data, 64'h0);
        chk("t5_err1", 64'(err), 64'h1);

        // reset mid-burst discards pending reads
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 16'h0008, 2'd1, 9'(16 + i), 64'h0, 1); step("t6r");
        end
        idle(1);
        do_reset();
        for (int i = 0; i < 6; i++) begin
            idle(0); step("t6d");
            chk("t6_no_cpl", 64'(c2_vld), 64'h0);
        end

        // randomized traffic in several reset-separated phases
        for (int ph = 0; ph < 4; ph++) begin
            do_reset();
            for (int n = 0; n < 200; n++) begin
                logic [15:0] a;
                logic [1:0]  l;
                a = ($urandom_range(0, 19) == 0) ? 16'($urandom)
                                                 : 16'($urandom_range(0, 2*(4+NS)+3));
                l = ($urandom_range(0, 60) == 0) ? 2'($urandom_range(2, 3))
                                                 : 2'($urandom_range(0, 1));
                drive(($urandom_range(0, 99) < 45), ($urandom_range(0, 99) < (ph == 3 ? 40 : 25)),
                      a, l, 9'($urandom), {$urandom, $urandom},
                      ($urandom_range(0, 99) < (ph == 1 ? 70 : 30)));
                if (ph != 3 && rd && wr) wr = 0;
                step("rnd");
            end
            for (int n = 0; n < DEP + 2; n++) begin
                idle(0); step("drain");
            end
            chk("drain_empty", 64'(q.size()), 64'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ccip_mmio_responder.md
Name: ccip_mmio_responder

Overview:
- AFU-side MMIO responder for the CCI-P interface. It is the target end of the MMIO read/write traffic that the host-side CCI-P emulator initiates.
- Decodes MMIO requests from c0 Rx, maintains the AFU's mandatory CSR header (DFH, AFU_ID) plus scratch registers, and returns read completions on c2 Tx.
- Buffers pending reads so that a test-only response stall does not lose completions.
- Instantiated inside ccip_std_afu, between the sRx/sTx ports and user logic.

Parameters:
- DFH_VALUE, 64'h1000_0000_0000_1000, value returned at DFH register.
- AFU_ID_L, 64'h0, low 64 bits of AFU GUID.
- AFU_ID_H, 64'h0, high 64 bits of AFU GUID.
- NUM_SCRATCH, 4, number of 64-bit R/W scratch registers (1..16).
- FIFO_DEPTH, 8, pending-read FIFO entries (power of 2, >=2).

Ports:
- pClk  in  1  CCI-P interface clock; all logic on rising edge.
- pck_cp2af_softReset_n  in  1  asynchronous active-low reset.
- c0_mmioRdValid  in  1  MMIO read request strobe, one cycle per request.
- c0_mmioWrValid  in  1  MMIO write request strobe.
- c0_mmio_address  in  16  request address, 4-byte units.
- c0_mmio_length  in  2  0 = 4 B, 1 = 8 B; other values are illegal.
- c0_mmio_tid  in  9  read transaction ID.
- c0_data  in  64  write data.
- c2_stall  in  1  test hook: when high, no completion is issued.
- c2_mmioRdValid  out  1  read completion strobe.
- c2_tid  out  9  completion transaction ID.
- c2_data  out  64  completion data.
- scratch_o  out  64*NUM_SCRATCH  current scratch contents, register i at bits [64i+63:64i].
- err_o  out  1  sticky protocol error.

Behaviour:
- Reset: async assert of pck_cp2af_softReset_n low. All outputs go to 0, scratch registers to 0, FIFO is emptied, err_o is cleared. Pending reads are discarded and no completion is ever issued for them. Deassertion is used directly; the source synchronises it.
- Register map, by byte address (= address*4):
  - DFH at 0x000
  - AFU_ID_L at 0x008
  - AFU_ID_H at 0x010
  - reserved at 0x018, reads 0
  - scratch i at 0x020+8i
  - all other addresses read 0, and writes to them are ignored.
- 8 B access:
  - requires address[0]=0.
  - If address[0]=1: reads return 0, writes are ignored, err_o is set.
- 4 B access:
  - The 8 B register at address&~1 is selected; address[0] selects the upper half when 1.
  - Read data is the selected 32 bits replicated in [63:32] and [31:0].
  - Write updates only the selected half, from c0_data[31:0].
- Illegal length (2 or 3): request is ignored, err_o is set.
- Writes: scratch updates at the same edge that samples c0_mmioWrValid. DFH and AFU_ID registers are read-only; writes to them are silently ignored.
- Reads:
  - At the sampling edge, {tid, read data} is snapshotted into the FIFO.
  - The data snapshot uses register values before any same-edge write. This preserves request order even while completions are stalled.
- Simultaneous c0_mmioRdValid and c0_mmioWrValid is a protocol violation. Both are processed, the read sees the pre-write value, and err_o is set.
- Issue stage: each cycle the FIFO is non-empty and c2_stall=0, pop one entry. Register it to c2_mmioRdValid/c2_tid/c2_data for exactly one cycle.
  - Otherwise c2_mmioRdValid=0, and c2_tid/c2_data hold their previous values.
- Latency with empty FIFO and no stall: request sampled at edge k; completion valid during the cycle after edge k+1 (2-cycle latency). Throughput is 1 completion/cycle.
- Simultaneous push and pop while the FIFO is full is allowed; the count is unchanged.
- FIFO full and a new read arrives with no pop that cycle: the request is dropped (no completion) and err_o is set.
- Count/pointer wrap at FIFO_DEPTH is modulo; use an extra pointer bit for full/empty.
- err_o stays set until reset.

Test Plan:
- Reset, then read 8 B at address 0x0000 with tid 0x05 -> 2 cycles later c2_mmioRdValid=1 for 1 cycle, c2_tid=0x05, c2_data=DFH_VALUE.
- Write 8 B 0xDEAD_BEEF_0123_4567 to address 0x0008 (scratch0), then 4 B read at 0x0009 with tid 0x1FF -> c2_data=0xDEADBEEF_DEADBEEF, c2_tid=0x1FF; scratch_o[63:0] reflects the write on the cycle after the write edge.
- Hold c2_stall=1, issue 8 back-to-back reads of scratch0 (tids 0..7), write 0x0 to scratch0 in the 9th cycle, then release stall -> 8 completions on consecutive cycles, tids 0..7 in order, all carrying the pre-write value; err_o=0.
- With stall held and FIFO full (8 entries), issue a 9th read -> no completion is ever produced for tid 8, and err_o=1 and stays 1.
- Write to 0x0002 (AFU_ID_L, read-only), then read it -> returns AFU_ID_L unchanged; 8 B read at odd address 0x0003 -> data 0, err_o=1.
- Queue 3 reads under stall, assert pck_cp2af_softReset_n low mid-burst, release, deassert stall -> no completions; all outputs 0; scratch registers 0.
